// File: rtl/toy_disp_pkg.sv
// Shared display constants for the front-panel seven-segment hardware.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package toy_disp_pkg;

    typedef logic [6:0] seg_t;

    // All segments dark; shown while the panel is held in reset.
    localparam seg_t SEG_BLANK = 7'h7F;

    // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg
    import toy_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; the table covers all 16 codes.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display scanner with leading-zero blanking and
// an overflow blink mode. Each digit is lit for REFRESH_DIV clocks; while
// the captured overflow flag is set the whole display toggles on/off every
// BLINK_SCANS complete scan rounds.
module seven_seg_scan
    import toy_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SCANS = 64
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [DATA_W-1:0] DATA,
    input  logic              OVF,
    input  logic              BLANK_EN,
    output logic [DIGITS-1:0] EN,
    output logic [6:0]        seven_seg_out
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

    logic [DATA_W-1:0] value_q, value_d;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic [DIGITS-1:0] en_q, en_d;
    logic [6:0]        seg_q, seg_d;

    logic              ref_wrap;
    logic              round_end;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              zero_above;
    logic [DIGITS-1:0] en_pat;
    logic [6:0]        dec_seg;

    // Capture of the datapath value and overflow flag.
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (LOAD) begin
            value_d = DATA;
            ovf_d   = OVF;
        end
    end

    // Refresh divider and digit index; a round ends when the last digit's
    // dwell expires.
    always_comb begin
        ref_wrap  = (ref_cnt_q == REF_LAST);
        round_end = ref_wrap && (idx_q == IDX_LAST);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Blink phase: counts whole rounds only while overflow is latched.
    // A capture that clears overflow restores a steady display on the same
    // edge, even though ovf_q itself only drops at that edge.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        blink_on_d = blink_on_q;
        if (!ovf_q) begin
            scan_cnt_d = '0;
            blink_on_d = 1'b1;
        end else if (round_end) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
        if (LOAD && !OVF) begin
            scan_cnt_d = '0;
            blink_on_d = 1'b1;
        end
    end

    // Select the active nibble and decide leading-zero blanking, walking
    // from the most significant digit down so zero_above covers d..top.
    always_comb begin
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        en_pat     = '1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            zero_above = zero_above && (value_q[4*d +: 4] == 4'h0);
            if (idx_q == IW'(d)) begin
                cur_nib   = value_q[4*d +: 4];
                en_pat[d] = 1'b0;
                if (d > 0) begin
                    cur_blank = BLANK_EN && zero_above;
                end
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Next values of the registered pin drivers. Segments are driven even
    // for a blanked digit; only the anode enable is suppressed.
    always_comb begin
        en_d  = (cur_blank || !blink_on_q) ? '1 : en_pat;
        seg_d = dec_seg;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            value_q    <= '0;
            ovf_q      <= 1'b0;
            ref_cnt_q  <= '0;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            blink_on_q <= 1'b1;
            en_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            value_q    <= value_d;
            ovf_q      <= ovf_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            blink_on_q <= blink_on_d;
            en_q       <= en_d;
            seg_q      <= seg_d;
        end
    end

    assign EN            = en_q;
    assign seven_seg_out = seg_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2.
// The reference model tracks the number of clock edges since reset and
// derives digit, blink phase and blanking from it arithmetically.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] DATA = 16'h0000;
    logic        OVF = 1'b0;
    logic        BLANK_EN = 1'b0;
    logic [3:0]  EN;
    logic [6:0]  seven_seg_out;

    int total = 0;
    int bad   = 0;

    logic [6:0] ref_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // model state: value, overflow, edges since reset, edge where overflow latched
    logic [15:0] m_val = 16'h0000;
    bit          m_ovf = 1'b0;
    int          m_k = 0;
    int          m_ovf_since = 0;

    always #5 CLK = ~CLK;

    seven_seg_scan #(
        .DIGITS      (4),
        .DATA_W      (16),
        .REFRESH_DIV (4),
        .BLINK_SCANS (2)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .LOAD          (LOAD),
        .DATA          (DATA),
        .OVF           (OVF),
        .BLANK_EN      (BLANK_EN),
        .EN            (EN),
        .seven_seg_out (seven_seg_out)
    );

    function automatic int m_idx();
        return (m_k / 4) % 4;
    endfunction

    // round ends happen at edges that are multiples of 16; each pair of them
    // after overflow latched flips the visible phase
    function automatic bit m_blink_on();
        if (!m_ovf) return 1'b1;
        return (((m_k / 16 - m_ovf_since / 16) / 2) % 2) == 0;
    endfunction

    function automatic logic [3:0] m_nib(input int i);
        logic [15:0] s;
        s = m_val >> (4 * i);
        return s[3:0];
    endfunction

    function automatic logic [3:0] m_en(input bit b);
        int i;
        logic [15:0] upper;
        i = m_idx();
        upper = m_val >> (4 * i);
        if (!m_blink_on()) return 4'hF;
        if (b && i > 0 && upper == 16'h0) return 4'hF;
        return ~(4'b0001 << i);
    endfunction

    task automatic check(input string tag, input logic [3:0] en_exp, input logic [6:0] seg_exp);
        total++;
        assert (EN === en_exp) else begin
            bad++;
            $error("FAIL %s EN observed=%b expected=%b (edge %0d)", tag, EN, en_exp, m_k);
        end
        total++;
        assert (seven_seg_out === seg_exp) else begin
            bad++;
            $error("FAIL %s seg observed=%h expected=%h (edge %0d)", tag, seven_seg_out, seg_exp, m_k);
        end
    endtask

    task automatic cyc(input bit ld, input logic [15:0] d, input bit o, input bit b, input string tag);
        logic [3:0] ee;
        logic [6:0] es;
        LOAD = ld; DATA = d; OVF = o; BLANK_EN = b;
        ee = m_en(b);
        es = ref_seg[m_nib(m_idx())];
        if (ld) begin
            m_val = d;
            if (!o) m_ovf = 1'b0;
            else if (!m_ovf) begin
                m_ovf = 1'b1;
                m_ovf_since = m_k + 1;
            end
        end
        m_k++;
        @(posedge CLK);
        @(negedge CLK);
        check(tag, ee, es);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b0; LOAD = 1'b1; DATA = 16'hFFFF; OVF = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            check("reset", 4'hF, 7'h7F);
        end
        m_val = 16'h0; m_ovf = 1'b0; m_k = 0; m_ovf_since = 0;
        RESET = 1'b1; LOAD = 1'b0; OVF = 1'b0;
    endtask

    initial begin
        bit found;
        logic [15:0] rd;

        do_reset(3);
        cyc(0, 16'h0, 0, 0, "first_edge");
        check("first_edge_abs", 4'hE, 7'h40);

        cyc(1, 16'h3A81, 0, 0, "scan_load");
        repeat (40) cyc(0, 16'h0, 0, 0, "scan");

        cyc(1, 16'h0007, 0, 1, "blank_load");
        repeat (20) cyc(0, 16'h0, 0, 1, "blank7");
        cyc(1, 16'h0000, 0, 1, "zero_load");
        repeat (20) cyc(0, 16'h0, 0, 1, "blank0");

        cyc(1, 16'h1234, 1, 0, "ovf_load");
        repeat (100) cyc(0, 16'h0, 0, 0, "blink");
        cyc(1, 16'h1234, 1, 0, "ovf_reload");
        repeat (20) cyc(0, 16'h0, 0, 0, "blink_keep");
        cyc(1, 16'h1234, 0, 0, "ovf_clear");
        repeat (20) cyc(0, 16'h0, 0, 0, "steady");

        cyc(1, 16'h5678, 1, 0, "ovf_load2");
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!m_blink_on() && m_idx() == 2) begin
                found = 1'b1;
                break;
            end
            cyc(0, 16'h0, 0, 0, "blink2");
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL mid_reset_setup observed=not_reached expected=dark_phase_idx2");
        end
        do_reset(1);
        repeat (60) cyc(0, 16'h0, 0, 0, "after_reset");

        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_k % 16 == 0) begin
                found = 1'b1;
                break;
            end
            cyc(0, 16'h0, 0, 0, "lat_wait");
        end
        cyc(1, 16'h000F, 0, 0, "lat_load");
        cyc(0, 16'h0, 0, 0, "lat_show");
        total++;
        assert (found && seven_seg_out === 7'h0E) else begin
            bad++;
            $error("FAIL load_latency observed=%h expected=0e", seven_seg_out);
        end

        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom) >> (4 * $urandom_range(0, 4));
            cyc($urandom_range(0, 7) == 0, rd, $urandom_range(0, 2) == 0,
                (i / 50) % 2 == 1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
